uart_fifo_dp: RTL and testbench

UART_FIFO_DP -- requirements
Module: uart_fifo_dp

---
 rtl/uart_fifo_dp.sv | 255 +++++++++++++++++++++++++
 tb/tb_uart_fifo_dp.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_fifo_dp.sv
// UART with TX/RX FIFOs behind a one-hot register bus, single clock domain.
// state | meaning (shared by TX and RX FSMs)
// IDLE  | line idle, waiting for data (TX) or a falling edge (RX)
// START | start bit: driven low (TX) / confirmed at half period (RX)
// DATA  | DATA_BITS data bits, LSB first
// STOP  | stop bit: driven high (TX) / checked at mid-bit (RX)
module uart_fifo_dp #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int BAUD_W     = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sel_tr,
  input  logic        sel_ctrl,
  input  logic        sel_baud,
  input  logic        sel_stat,
  input  logic        enable,
  input  logic        write,
  input  logic [31:0] data_out,
  input  logic        rx_in,
  output logic [31:0] data_in,
  output logic        tx_out,
  output logic        tx_en,
  output logic        irq
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic                 wr, rd;
  logic [3:0]           ctrl;
  logic [BAUD_W-1:0]    divisor;
  logic                 err_clr, frame_err, overrun, fe_set, ov_set;

  logic [DATA_BITS-1:0] tx_mem [FIFO_DEPTH];
  logic [AW:0]          tx_wp, tx_rp;
  logic                 tx_empty, tx_full, tx_push, tx_pop;

  logic [DATA_BITS-1:0] rx_mem [FIFO_DEPTH];
  logic [AW:0]          rx_wp, rx_rp;
  logic                 rx_empty, rx_full, rx_push, rx_pop;

  state_t               tx_state, tx_next;
  logic [BAUD_W-1:0]    tx_cnt;
  logic [BW-1:0]        tx_bit;
  logic [DATA_BITS-1:0] tx_sh;
  logic                 tx_tick, tx_go;

  state_t               rx_state, rx_next;
  logic [BAUD_W-1:0]    rx_cnt, half;
  logic [BAUD_W:0]      div_p1;
  logic [BW-1:0]        rx_bit;
  logic [DATA_BITS-1:0] rx_sh;
  logic                 rx_s1, rx_s2, rx_prev, rx_tick, rx_half;
  logic                 unused_bus;

  assign wr       = enable & write;
  assign rd       = enable & ~write;
  assign err_clr  = wr & sel_ctrl & data_out[4];
  assign div_p1   = {1'b0, divisor} + (BAUD_W + 1)'(1);
  assign half     = div_p1[BAUD_W:1];
  assign unused_bus = ^{data_out, div_p1[0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl    <= '0;
      divisor <= '0;
    end else begin
      if (wr && sel_ctrl) ctrl <= data_out[3:0];
      if (wr && sel_baud) divisor <= data_out[BAUD_W-1:0];
    end
  end

  // Full/empty come from comparing the extra pointer MSB.
  assign tx_empty = (tx_wp == tx_rp);
  assign tx_full  = (tx_wp[AW] != tx_rp[AW]) && (tx_wp[AW-1:0] == tx_rp[AW-1:0]);
  assign rx_empty = (rx_wp == rx_rp);
  assign rx_full  = (rx_wp[AW] != rx_rp[AW]) && (rx_wp[AW-1:0] == rx_rp[AW-1:0]);
  assign tx_push  = wr & sel_tr & ~tx_full;
  assign rx_pop   = rd & sel_tr & ~rx_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_wp <= '0;
      tx_rp <= '0;
      rx_wp <= '0;
      rx_rp <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        tx_mem[i] <= '0;
        rx_mem[i] <= '0;
      end
    end else begin
      if (tx_push) begin
        tx_mem[tx_wp[AW-1:0]] <= data_out[DATA_BITS-1:0];
        tx_wp <= tx_wp + (AW + 1)'(1);
      end
      if (tx_pop) tx_rp <= tx_rp + (AW + 1)'(1);
      if (rx_push) begin
        rx_mem[rx_wp[AW-1:0]] <= rx_sh;
        rx_wp <= rx_wp + (AW + 1)'(1);
      end
      if (rx_pop) rx_rp <= rx_rp + (AW + 1)'(1);
    end
  end

  assign tx_tick = (tx_cnt == '0);
  assign tx_go   = ctrl[0] & ~tx_empty;

  always_comb begin
    tx_next = tx_state;
    tx_pop  = 1'b0;
    case (tx_state)
      IDLE:  if (tx_go) begin
               tx_next = START;
               tx_pop  = 1'b1;
             end
      START: if (tx_tick) tx_next = DATA;
      DATA:  if (tx_tick && tx_bit == '0) tx_next = STOP;
      STOP:  if (tx_tick) begin
               if (tx_go) begin
                 tx_next = START;
                 tx_pop  = 1'b1;
               end else begin
                 tx_next = IDLE;
               end
             end
      default: tx_next = IDLE;
    endcase
  end

  // The bit timer reloads from divisor at every boundary, so new rates start cleanly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state <= IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_sh    <= '0;
    end else begin
      tx_state <= tx_next;
      if (tx_pop) begin
        tx_sh  <= tx_mem[tx_rp[AW-1:0]];
        tx_cnt <= divisor;
      end else if (tx_state != IDLE) begin
        if (tx_tick) begin
          tx_cnt <= divisor;
          if (tx_state == START) tx_bit <= LAST_BIT;
          if (tx_state == DATA) begin
            tx_sh  <= tx_sh >> 1;
            tx_bit <= tx_bit - BW'(1);
          end
        end else begin
          tx_cnt <= tx_cnt - BAUD_W'(1);
        end
      end
    end
  end

  assign tx_out = (tx_state == START) ? 1'b0 : (tx_state == DATA) ? tx_sh[0] : 1'b1;
  assign tx_en  = (tx_state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= rx_in;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  assign rx_tick = (rx_cnt == '0);
  assign rx_half = (rx_cnt <= BAUD_W'(1));

  always_comb begin
    rx_next = rx_state;
    rx_push = 1'b0;
    fe_set  = 1'b0;
    ov_set  = 1'b0;
    case (rx_state)
      IDLE:  if (ctrl[1] && rx_prev && !rx_s2) rx_next = START;
      START: if (rx_half) rx_next = rx_s2 ? IDLE : DATA;
      DATA:  if (rx_tick && rx_bit == '0) rx_next = STOP;
      STOP:  if (rx_tick) begin
               rx_next = IDLE;
               if (!rx_s2)      fe_set  = 1'b1;
               else if (rx_full) ov_set  = 1'b1;
               else             rx_push = 1'b1;
             end
      default: rx_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state <= IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_sh    <= '0;
    end else begin
      rx_state <= rx_next;
      case (rx_state)
        IDLE:  rx_cnt <= half;
        START: if (rx_half) begin
                 rx_cnt <= divisor;
                 rx_bit <= LAST_BIT;
               end else begin
                 rx_cnt <= rx_cnt - BAUD_W'(1);
               end
        default: if (rx_tick) begin
                   rx_cnt <= divisor;
                   if (rx_state == DATA) begin
                     rx_sh  <= {rx_s2, rx_sh[DATA_BITS-1:1]};
                     rx_bit <= rx_bit - BW'(1);
                   end
                 end else begin
                   rx_cnt <= rx_cnt - BAUD_W'(1);
                 end
      endcase
    end
  end

  // A set in the same cycle as a clear wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      irq       <= 1'b0;
    end else begin
      frame_err <= fe_set | (frame_err & ~err_clr);
      overrun   <= ov_set | (overrun & ~err_clr);
      irq       <= (ctrl[2] & ~rx_empty) | (ctrl[3] & tx_empty & ~tx_en) | overrun | frame_err;
    end
  end

  always_comb begin
    data_in = '0;
    if (rd) begin
      if (sel_tr) begin
        if (!rx_empty) data_in[DATA_BITS-1:0] = rx_mem[rx_rp[AW-1:0]];
      end else if (sel_ctrl) begin
        data_in[3:0] = ctrl;
      end else if (sel_baud) begin
        data_in[BAUD_W-1:0] = divisor;
      end else if (sel_stat) begin
        data_in[6:0] = {tx_en, frame_err, overrun, rx_empty, rx_full, tx_empty, tx_full};
      end
    end
  end

endmodule

// File: tb/tb_uart_fifo_dp.sv
// Self-checking bench for uart_fifo_dp: a frame-timeline model of the TX line
// checked every cycle, plus directed register/RX scenarios with literal expectations.
module tb_uart_fifo_dp;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel_tr = 1'b0, sel_ctrl = 1'b0, sel_baud = 1'b0, sel_stat = 1'b0;
  logic        enable = 1'b0, write = 1'b0;
  logic [31:0] data_out = '0;
  logic        rx_drv = 1'b1, loop_en = 1'b0, rx_line;
  logic [31:0] data_in;
  logic        tx_out, tx_en, irq;

  localparam int TR = 0, CTRL = 1, BAUD = 2, STAT = 3;

  always #5 clk = ~clk;
  assign rx_line = loop_en ? tx_out : rx_drv;

  uart_fifo_dp dut (
    .clk(clk), .rst(rst), .sel_tr(sel_tr), .sel_ctrl(sel_ctrl), .sel_baud(sel_baud),
    .sel_stat(sel_stat), .enable(enable), .write(write), .data_out(data_out),
    .rx_in(rx_line), .data_in(data_in), .tx_out(tx_out), .tx_en(tx_en), .irq(irq)
  );

  int n_cmp = 0, n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // TX model: FIFO as a queue, each frame a 10-bit-period window on a cycle timeline.
  logic [7:0] m_q[$];
  bit         m_busy;
  int         m_cyc, m_start, m_per, m_div, m_frames, m_sz0;
  logic [7:0] m_byte;
  logic [3:0] m_ctrl;

  always @(posedge clk) begin
    if (rst) begin
      m_q.delete();
      m_busy = 0; m_ctrl = '0; m_div = 0; m_cyc = 0; m_frames = 0;
    end else begin
      m_sz0 = m_q.size();
      m_cyc++;
      if (m_busy && (m_cyc - m_start) >= 10 * m_per) m_busy = 0;
      if (!m_busy && m_ctrl[0] && m_q.size() != 0) begin
        m_byte = m_q.pop_front();
        m_busy = 1; m_start = m_cyc; m_per = m_div + 1; m_frames++;
      end
      if (enable && write) begin
        if (sel_tr && m_sz0 < 8) m_q.push_back(data_out[7:0]);
        if (sel_ctrl) m_ctrl = data_out[3:0];
        if (sel_baud) m_div = int'(data_out[19:0]);
      end
    end
  end

  logic c_out, c_en;
  int   c_b;
  always @(negedge clk) begin
    if (rst || !m_busy) begin
      c_out = 1'b1; c_en = 1'b0;
    end else begin
      c_b  = (m_cyc - m_start) / m_per;
      c_en = 1'b1;
      c_out = (c_b == 0) ? 1'b0 : (c_b <= 8) ? m_byte[c_b-1] : 1'b1;
    end
    check("tx_line{en,out}", {30'b0, tx_en, tx_out}, {30'b0, c_en, c_out});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_sel(input int w, input logic on);
    sel_tr   = on && (w == TR);
    sel_ctrl = on && (w == CTRL);
    sel_baud = on && (w == BAUD);
    sel_stat = on && (w == STAT);
  endtask

  task automatic bus_write(input int w, input logic [31:0] d);
    set_sel(w, 1'b1); enable = 1'b1; write = 1'b1; data_out = d;
    tick();
    set_sel(w, 1'b0); enable = 1'b0; write = 1'b0; data_out = '0;
  endtask

  task automatic bus_read(input int w, output logic [31:0] d);
    set_sel(w, 1'b1); enable = 1'b1; write = 1'b0;
    #1 d = data_in;
    tick();
    set_sel(w, 1'b0); enable = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; loop_en = 1'b0; rx_drv = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic wait_tx_en();
    int k = 0;
    while (!tx_en && k < 50) begin tick(); k++; end
    check("tx_start_timeout", 32'(tx_en), 32'h1);
  endtask

  // Drives one character at 4 clocks per bit (divisor 3), then two idle clocks.
  task automatic send_rx(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx_drv = f[i];
      repeat (4) tick();
    end
    rx_drv = 1'b1;
    repeat (2) tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    int en_cnt, low;
    logic [9:0] vec;
    bit seen_one;

    do_reset();
    check("rst_tx_out", 32'(tx_out), 32'h1);
    check("rst_tx_en", 32'(tx_en), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    check("idle_data_in", data_in, 32'h0);
    bus_read(CTRL, r); check("rst_ctrl", r, 32'h0);
    bus_read(BAUD, r); check("rst_baud", r, 32'h0);
    bus_read(STAT, r); check("rst_status", r, 32'h0A);
    bus_read(TR, r);   check("empty_rx_read", r, 32'h0);

    bus_write(CTRL, 32'h08);
    repeat (2) tick();
    check("irq_tx_empty", 32'(irq), 32'h1);
    bus_read(CTRL, r); check("ctrl_readback", r, 32'h08);

    // Single 0xA5 frame at 4 clocks per bit.
    do_reset();
    bus_write(BAUD, 32'h3);
    bus_read(BAUD, r); check("baud_readback", r, 32'h3);
    bus_write(CTRL, 32'h1);
    bus_write(TR, 32'hA5);
    wait_tx_en();
    en_cnt = 0; low = 0; seen_one = 0; vec = '0;
    while (tx_en && en_cnt < 100) begin
      if (tx_out) seen_one = 1;
      else if (!seen_one) low++;
      if (en_cnt % 4 == 2 && en_cnt / 4 < 10) vec[en_cnt/4] = tx_out;
      en_cnt++;
      tick();
    end
    check("a5_tx_en_cycles", 32'(en_cnt), 32'd40);
    check("a5_start_low_cycles", 32'(low), 32'd4);
    check("a5_line_bits", 32'(vec), 32'h34A);

    // Nine writes into an 8-deep FIFO; the ninth is dropped.
    do_reset();
    bus_write(BAUD, 32'h3);
    for (int i = 0; i < 9; i++) bus_write(TR, 32'h10 + 32'(i));
    bus_read(STAT, r); check("tx_full_status", r, 32'h09);
    check("model_queue_depth", 32'(m_q.size()), 32'd8);
    bus_write(CTRL, 32'h1);
    wait_tx_en();
    en_cnt = 0;
    while (tx_en && en_cnt < 400) begin en_cnt++; tick(); end
    check("eight_frames_cycles", 32'(en_cnt), 32'd320);
    check("model_frames", 32'(m_frames), 32'd8);
    bus_read(STAT, r); check("after_burst_status", r, 32'h0A);

    // Loopback of 0x3C.
    do_reset();
    bus_write(BAUD, 32'h3);
    bus_write(CTRL, 32'h3);
    loop_en = 1'b1;
    bus_write(TR, 32'h3C);
    repeat (50) tick();
    bus_read(STAT, r); check("loop_status_full", r, 32'h02);
    bus_read(TR, r);   check("loop_rx_data", r, 32'h3C);
    bus_read(STAT, r); check("loop_status_empty", r, 32'h0A);
    loop_en = 1'b0;

    // Framing error and clear.
    do_reset();
    bus_write(BAUD, 32'h3);
    bus_write(CTRL, 32'h3);
    send_rx(8'h5A, 1'b0);
    repeat (2) tick();
    bus_read(STAT, r); check("frame_err_status", r, 32'h2A);
    check("frame_err_irq", 32'(irq), 32'h1);
    bus_write(CTRL, 32'h13);
    repeat (2) tick();
    bus_read(STAT, r); check("frame_err_cleared", r, 32'h0A);
    check("frame_err_irq_clear", 32'(irq), 32'h0);
    bus_read(CTRL, r); check("ctrl_clear_not_stored", r, 32'h03);

    // Overrun: nine characters, no reads.
    do_reset();
    bus_write(BAUD, 32'h3);
    bus_write(CTRL, 32'h3);
    for (int i = 0; i < 9; i++) send_rx(8'h41 + 8'(i), 1'b1);
    bus_read(STAT, r); check("overrun_status", r, 32'h16);
    check("overrun_irq", 32'(irq), 32'h1);
    for (int i = 0; i < 8; i++) begin
      bus_read(TR, r);
      check($sformatf("rx_order_%0d", i), r, 32'h41 + 32'(i));
    end
    bus_read(STAT, r); check("overrun_sticky", r, 32'h1A);

    // Reset in the middle of data bit 3.
    do_reset();
    bus_write(BAUD, 32'h3);
    bus_write(CTRL, 32'h1);
    bus_write(TR, 32'h55);
    wait_tx_en();
    repeat (17) tick();
    check("pre_rst_tx_en", 32'(tx_en), 32'h1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_tx_out", 32'(tx_out), 32'h1);
    check("async_rst_tx_en", 32'(tx_en), 32'h0);
    tick(); tick();
    rst = 1'b0;
    tick();
    bus_read(STAT, r); check("post_rst_status", r, 32'h0A);
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
